// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment constants, FSM state type and field geometry
// Segments are active-low, bit0=a through bit6=g.
package display_pkg;

  localparam int DIGITS_PER_FIELD = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_STORE
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - one BCD digit to active-low seven-segment pattern
// Codes 10..15 never come out of the converter and decode to blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/display_fields_seq.sv
// rtl/display_fields_seq.sv - round-robin double-dabble conversion of fields to 7-segment digits
// Define DISPLAY_BLINK_EN to blink the edited field; otherwise it is held blank.
module display_fields_seq
  import display_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 7,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
  input  logic [2:0]                    edit_sel,
  output logic [NUM_FIELDS*14-1:0]      hex,
  output logic                          frame_done
);

  localparam int         HEX_W      = DIGITS_PER_FIELD * 7;
  localparam logic [1:0] LAST_IDX   = 2'(NUM_FIELDS - 1);
  localparam logic [2:0] LAST_SHIFT = 3'(FIELD_W - 1);

  state_t                      state;
  state_t                      state_nxt;
  logic [1:0]                  idx;
  logic [2:0]                  shift_cnt;
  logic [FIELD_W-1:0]          sr;
  logic [11:0]                 bcd;
  logic [11:0]                 bcd_adj;
  logic [NUM_FIELDS*HEX_W-1:0] hex_reg;
  logic [6:0]                  seg_tens;
  logic [6:0]                  seg_ones;
  logic [HEX_W-1:0]            field_hex;
  logic                        masked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (shift_cnt == LAST_SHIFT) state_nxt = ST_STORE;
      ST_STORE: state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Add-3 correction on every BCD digit before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  seg7_decode u_tens (.bcd(bcd[7:4]), .seg(seg_tens));
  seg7_decode u_ones (.bcd(bcd[3:0]), .seg(seg_ones));

  assign field_hex = (bcd[11:8] != 4'd0) ? {SEG_DASH, SEG_DASH} : {seg_tens, seg_ones};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      shift_cnt  <= 3'd0;
      sr         <= '0;
      bcd        <= '0;
      hex_reg    <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_STORE) && (idx == LAST_IDX);
      case (state)
        ST_LOAD: begin
          for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx == 2'(k)) sr <= fields[k*FIELD_W +: FIELD_W];
          end
          bcd       <= '0;
          shift_cnt <= 3'd0;
        end
        ST_SHIFT: begin
          {bcd, sr} <= {bcd_adj, sr} << 1;
          shift_cnt <= shift_cnt + 3'd1;
        end
        ST_STORE: begin
          for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx == 2'(k)) hex_reg[k*HEX_W +: HEX_W] <= field_hex;
          end
          idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic [2:0]       prev_sel;

  // A new selection restarts the blink so the newly chosen field starts visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      prev_sel    <= 3'd0;
    end else begin
      prev_sel <= edit_sel;
      if (edit_sel != prev_sel) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  assign masked = ~blink_phase;
`else
  assign masked = 1'b1;
`endif

  always_comb begin
    hex = hex_reg;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (masked && (edit_sel == 3'(k + 1))) hex[k*HEX_W +: HEX_W] = '1;
    end
  end

endmodule

// File: tb/tb_display_fields_seq.sv
// tb/tb_display_fields_seq.sv - self-checking bench for display_fields_seq
// Blink expectations follow DISPLAY_BLINK_EN as defined for the build.
module tb_display_fields_seq;

  localparam int NF = 3;
  localparam int FW = 7;
  localparam int BD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NF*FW-1:0]  fields;
  logic [2:0]        edit_sel;
  logic [NF*14-1:0]  hex;
  logic              frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_fields_seq #(
    .NUM_FIELDS(NF),
    .FIELD_W   (FW),
    .BLINK_DIV (BD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fields    (fields),
    .edit_sel  (edit_sel),
    .hex       (hex),
    .frame_done(frame_done)
  );

  typedef struct {
    int v [3];
    int t [3];
    int o [3];
  } vec_t;

  vec_t tbl [4];

  // Digit 10 stands for the dash.
  function automatic logic [6:0] seg(input int d);
    logic [6:0] on;
    case (d)
      0:       on = 7'h3F;
      1:       on = 7'h06;
      2:       on = 7'h5B;
      3:       on = 7'h4F;
      4:       on = 7'h66;
      5:       on = 7'h6D;
      6:       on = 7'h7D;
      7:       on = 7'h07;
      8:       on = 7'h7F;
      9:       on = 7'h6F;
      10:      on = 7'h40;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  function automatic logic [13:0] field_code(input int v);
    if (v > 99) return {seg(10), seg(10)};
    return {seg(v / 10), seg(v % 10)};
  endfunction

  function automatic logic [41:0] frame_code(input int a, input int b, input int c);
    return {field_code(c), field_code(b), field_code(a)};
  endfunction

  function automatic bit blanked(input int t);
`ifdef DISPLAY_BLINK_EN
    return ((t / BD) % 2) == 1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int a, input int b, input int c);
    fields = {7'(c), 7'(b), 7'(a)};
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0d expected=frame_done", n);
    end
  endtask

  initial begin
    int          n;
    int          t;
    int          sel;
    int          a, b, c;
    logic [41:0] base;
    logic [41:0] exp;

    tbl[0].v = '{7, 45, 23};   tbl[0].t = '{0, 4, 2};   tbl[0].o = '{7, 5, 3};
    tbl[1].v = '{5, 100, 127}; tbl[1].t = '{0, 10, 10}; tbl[1].o = '{5, 10, 10};
    tbl[2].v = '{0, 99, 10};   tbl[2].t = '{0, 9, 1};   tbl[2].o = '{0, 9, 0};
    tbl[3].v = '{9, 50, 81};   tbl[3].t = '{0, 5, 8};   tbl[3].o = '{9, 0, 1};

    rst_n    = 1'b0;
    fields   = '0;
    edit_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hex", hex, {42{1'b1}});
    chk("reset_frame_done", frame_done, 1'b0);

    set_fields(7, 45, 23);
    rst_n = 1'b1;
    wait_frame(n);
    chk("first_frame_latency", n, 27);
    chk("first_frame_hex", hex, frame_code(7, 45, 23));

    for (int i = 0; i < 4; i++) begin
      set_fields(tbl[i].v[0], tbl[i].v[1], tbl[i].v[2]);
      wait_frame(n);
      chk($sformatf("tbl%0d_period", i), n, 27);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("tbl%0d_field%0d", i, k), hex[k*14 +: 14],
            {seg(tbl[i].t[k]), seg(tbl[i].o[k])});
      end
    end

    @(posedge clk);
    #1;
    chk("frame_done_width", frame_done, 1'b0);
    wait_frame(n);

    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 127));
      b = int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 127));
      set_fields(a, b, c);
      wait_frame(n);
      chk($sformatf("rand%0d_period", i), n, 27);
      chk($sformatf("rand%0d_hex_%0d_%0d_%0d", i, a, b, c), hex, frame_code(a, b, c));
    end

    set_fields(12, 1, 2);
    wait_frame(n);
    chk("snap_before", hex[13:0], field_code(12));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    set_fields(34, 1, 2);
    wait_frame(n);
    chk("snap_same_frame", hex[13:0], field_code(12));
    wait_frame(n);
    chk("snap_next_frame", hex[13:0], field_code(34));

    set_fields(7, 45, 23);
    wait_frame(n);
    base = frame_code(7, 45, 23);

    edit_sel = 3'd2;
    sel = 2;
    t = 0;
    for (int j = 0; j < 24; j++) begin
      @(posedge clk);
      #1;
      exp = base;
      if (blanked(t)) exp[(sel-1)*14 +: 14] = 14'h3FFF;
      chk($sformatf("blink_j%0d_sel%0d", j, sel), hex, exp);
      t++;
      if (j == 5) begin
        edit_sel = 3'd3;
        sel = 3;
        t = 0;
      end
    end

    edit_sel = 3'd7;
    @(posedge clk);
    #1;
    chk("sel_out_of_range", hex, base);
    edit_sel = 3'd0;

    wait_frame(n);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midshift_reset_hex", hex, {42{1'b1}});
    chk("midshift_reset_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_frame(n);
    chk("restart_latency", n, 27);
    chk("restart_hex", hex, base);

    edit_sel = 3'd1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      exp = base;
      if (blanked(j)) exp[13:0] = 14'h3FFF;
      chk($sformatf("sel1_j%0d", j), hex, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
